// File: rtl/motor_pkg.sv
// Shared motor-control types: duty width/limit, duty type and ramp FSM states.
package motor_pkg;

    localparam int unsigned DUTY_W   = 7;
    localparam logic [6:0]  DUTY_MAX = 7'd100;

    typedef logic [DUTY_W-1:0] duty_t;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ramp_state_e;

    // Saturate an 8-bit intermediate duty value to the 0..100 percent range.
    function automatic duty_t clamp_duty(input logic [7:0] v);
        return (v > {1'b0, DUTY_MAX}) ? DUTY_MAX : v[DUTY_W-1:0];
    endfunction

endpackage

// File: rtl/duty_ramp_tick.sv
// Free-running step-interval counter: counts 0..TICKS-1 while enabled, pulses wrap on the last count.
module duty_ramp_tick #(
    parameter int unsigned TICKS = 100_000
) (
    input  logic clk,
    input  logic clr,
    input  logic sclr,
    input  logic en,
    output logic wrap
);

    localparam int unsigned CW   = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] count;

    assign wrap = en && !sclr && (count == LAST);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= '0;
        end else if (sclr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/duty_ramp.sv
// Duty-cycle slew limiter feeding the PWM load pair (duty_cycle/en).
// Optional command-silence watchdog enabled by defining DUTY_RAMP_WATCHDOG_EN.
//
// state | meaning
// IDLE  | duty settled at target, commands accepted when estop is low
// RAMP  | stepping duty toward target once per tick wrap
module duty_ramp
    import motor_pkg::*;
#(
    parameter logic [16:0] RAMP_TICKS = 17'd100_000,
    parameter logic [6:0]  STEP       = 7'd5,
    parameter logic [31:0] WDT_CYCLES = 32'd50_000_000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [6:0] cmd_target,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       estop,
    output logic [6:0] duty_cycle,
    output logic       en,
    output logic       busy,
    output logic       wdt_trip
);

    if (RAMP_TICKS == 17'd0 || STEP == 7'd0 || STEP > DUTY_MAX || WDT_CYCLES == 32'd0) begin : g_bad_cfg
        $error("duty_ramp: parameter out of range");
    end

    ramp_state_e state;
    duty_t       target_q;
    duty_t       goal;
    duty_t       next_duty;
    duty_t       cmd_clamped;
    logic [7:0]  cur8;
    logic [7:0]  goal8;
    logic [7:0]  diff;
    logic [7:0]  delta;
    logic [7:0]  sum;
    logic        accept;
    logic        wdt_expire;
    logic        tick_wrap;

    assign cmd_ready   = (state == IDLE) && !estop && !clr;
    assign accept      = cmd_valid && cmd_ready;
    assign cmd_clamped = clamp_duty({1'b0, cmd_target});

    // A watchdog expiry retargets to zero in the same cycle it is seen.
    assign goal  = wdt_expire ? '0 : target_q;
    assign cur8  = {1'b0, duty_cycle};
    assign goal8 = {1'b0, goal};
    assign diff  = (goal8 > cur8) ? goal8 - cur8 : cur8 - goal8;
    assign delta = (diff > {1'b0, STEP}) ? {1'b0, STEP} : diff;
    assign sum   = (goal8 > cur8) ? cur8 + delta : cur8 - delta;
    assign next_duty = clamp_duty(sum);

    duty_ramp_tick #(
        .TICKS (32'(RAMP_TICKS))
    ) u_tick (
        .clk  (clk),
        .clr  (clr),
        .sclr (estop || (state != RAMP)),
        .en   (state == RAMP),
        .wrap (tick_wrap)
    );

`ifdef DUTY_RAMP_WATCHDOG_EN
    logic [31:0] wdt_cnt;
    logic        wdt_trip_q;

    assign wdt_expire = !wdt_trip_q && !accept && (wdt_cnt == WDT_CYCLES - 32'd1);
    assign wdt_trip   = wdt_trip_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wdt_cnt    <= '0;
            wdt_trip_q <= 1'b0;
        end else if (accept) begin
            wdt_cnt    <= '0;
            wdt_trip_q <= 1'b0;
        end else if (wdt_expire) begin
            wdt_trip_q <= 1'b1;
        end else if (!wdt_trip_q) begin
            wdt_cnt <= wdt_cnt + 32'd1;
        end
    end
`else
    assign wdt_expire = 1'b0;
    assign wdt_trip   = 1'b0;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            duty_cycle <= '0;
            target_q   <= '0;
            en         <= 1'b0;
            busy       <= 1'b0;
        end else begin
            en <= 1'b0;
            if (estop) begin
                en         <= (duty_cycle != '0);
                duty_cycle <= '0;
                target_q   <= '0;
                state      <= IDLE;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            target_q <= cmd_clamped;
                            if (cmd_clamped != duty_cycle) begin
                                state <= RAMP;
                                busy  <= 1'b1;
                            end
                        end else if (wdt_expire) begin
                            target_q <= '0;
                            if (duty_cycle != '0) begin
                                state <= RAMP;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    RAMP: begin
                        if (wdt_expire) begin
                            target_q <= '0;
                        end
                        if (wdt_expire && duty_cycle == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (tick_wrap) begin
                            duty_cycle <= next_duty;
                            en         <= (next_duty != duty_cycle);
                            if (next_duty == goal) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_duty_ramp.sv
// Self-checking bench for duty_ramp: directed scenarios plus random traffic against a behavioural model.
module tb_duty_ramp;

    localparam int RT   = 4;
    localparam int STP  = 5;
    localparam int WDT  = 50;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [6:0] cmd_target = '0;
    logic       cmd_valid = 1'b0;
    logic       estop = 1'b0;
    logic       cmd_ready;
    logic [6:0] duty_cycle;
    logic       en;
    logic       busy;
    logic       wdt_trip;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model state
    int m_duty, m_target, m_phase, m_wdt;
    bit m_busy, m_en, m_trip;
    int en_cnt;

    always #5 clk = ~clk;

    duty_ramp #(
        .RAMP_TICKS (17'(RT)),
        .STEP       (7'(STP)),
        .WDT_CYCLES (32'(WDT))
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .cmd_target (cmd_target),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .estop      (estop),
        .duty_cycle (duty_cycle),
        .en         (en),
        .busy       (busy),
        .wdt_trip   (wdt_trip)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_duty = 0; m_target = 0; m_phase = 0; m_wdt = 0;
        m_busy = 0; m_en = 0; m_trip = 0;
    endtask

    function automatic bit m_ready();
        return !m_busy && !estop && !clr;
    endfunction

    // One clock of the reference behaviour, evaluated from the inputs present before the edge.
    task automatic model_step();
        bit acc, expire, was_busy;
        int old, d;
        acc = cmd_valid && m_ready();
        was_busy = m_busy;
        expire = 0;
        m_en = 0;
`ifdef DUTY_RAMP_WATCHDOG_EN
        expire = !m_trip && !acc && (m_wdt == WDT - 1);
        if (acc) begin
            m_wdt = 0; m_trip = 0;
        end else if (expire) begin
            m_trip = 1;
        end else if (!m_trip) begin
            m_wdt++;
        end
`endif
        if (estop) begin
            m_en = (m_duty != 0);
            m_duty = 0; m_target = 0; m_busy = 0; m_phase = 0;
        end else if (acc) begin
            m_target = (cmd_target > 100) ? 100 : int'(cmd_target);
            if (m_target != m_duty) begin
                m_busy = 1; m_phase = 0;
            end
        end else begin
            if (expire) begin
                m_target = 0;
                if (m_duty == 0) m_busy = 0;
                else if (!was_busy) begin
                    m_busy = 1; m_phase = 0;
                end
            end
            if (was_busy && m_busy) begin
                m_phase++;
                if (m_phase == RT) begin
                    m_phase = 0;
                    old = m_duty;
                    d = m_target - m_duty;
                    if (d > STP) d = STP;
                    if (d < -STP) d = -STP;
                    m_duty = m_duty + d;
                    m_en = (m_duty != old);
                    if (m_duty == m_target) m_busy = 0;
                end
            end
        end
    endtask

    // Inputs are already applied; check ready, clock once, then check registered outputs.
    task automatic tick();
        #1;
        check("cmd_ready", 32'(cmd_ready), 32'(m_ready()));
        model_step();
        @(posedge clk);
        #1;
        check("duty_cycle", 32'(duty_cycle), 32'(m_duty));
        check("en", 32'(en), 32'(m_en));
        check("busy", 32'(busy), 32'(m_busy));
        check("wdt_trip", 32'(wdt_trip), 32'(m_trip));
        if (en) en_cnt++;
    endtask

    task automatic drive(input bit v, input int t, input bit e);
        cmd_valid  = v;
        cmd_target = 7'(t);
        estop      = e;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int guard;
        m_reset();
        #2;
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_duty", 32'(duty_cycle), 32'd0);
        check("rst_en", 32'(en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_trip", 32'(wdt_trip), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        clr = 1'b0;
        #1;
        check("rel_ready", 32'(cmd_ready), 32'd1);

        // ramp 0 -> 40: eight steps of 5, one en each
        drive(1, 40, 0); tick();
        drive(0, 0, 0); en_cnt = 0;
        ticks(RT - 1);
        check("t1_first_hold", 32'(duty_cycle), 32'd0);
        tick();
        check("t1_first_step", 32'(duty_cycle), 32'd5);
        ticks(8 * RT - RT);
        check("t1_duty", 32'(duty_cycle), 32'd40);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_en_count", 32'(en_cnt), 32'd8);

        // 40 -> 37: single partial step, no overshoot
        drive(1, 37, 0); tick();
        drive(0, 0, 0); en_cnt = 0;
        ticks(RT + 2);
        check("t2_duty", 32'(duty_cycle), 32'd37);
        check("t2_en_count", 32'(en_cnt), 32'd1);

        // command equal to current duty: nothing happens
        drive(1, 37, 0); en_cnt = 0; tick();
        drive(0, 0, 0); ticks(RT + 1);
        check("t3b_busy", 32'(busy), 32'd0);
        check("t3b_en_count", 32'(en_cnt), 32'd0);

        // estop mid-ramp at duty 25 with a command pending
        drive(0, 0, 1); tick();
        drive(1, 50, 0); tick();
        drive(0, 0, 0);
        guard = 0;
        while (m_duty != 25 && guard < 40) begin
            tick(); guard++;
        end
        check("t4_reach25", 32'(duty_cycle), 32'd25);
        drive(1, 90, 1); en_cnt = 0; tick();
        check("t4_duty0", 32'(duty_cycle), 32'd0);
        check("t4_en", 32'(en), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        drive(0, 0, 0);
        #1;
        check("t4_ready_after", 32'(cmd_ready), 32'd1);
        ticks(RT * 3);
        check("t4_dropped", 32'(duty_cycle), 32'd0);
        check("t4_en_count", 32'(en_cnt), 32'd1);

        // clamp 120 -> 100
        drive(1, 120, 0); tick();
        drive(0, 0, 0);
        ticks(20 * RT + 4);
`ifndef DUTY_RAMP_WATCHDOG_EN
        check("t3_clamp", 32'(duty_cycle), 32'd100);
        check("t3_busy", 32'(busy), 32'd0);
`endif

        // async clear mid-ramp
        drive(1, 0, 0); tick();
        drive(1, 60, 0); tick();
        drive(0, 0, 0); ticks(2 * RT + 1);
        clr = 1'b1;
        #2;
        m_reset();
        check("t5_duty", 32'(duty_cycle), 32'd0);
        check("t5_en", 32'(en), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        tick();
        check("t5_ready_after", 32'(cmd_ready), 32'd1);

`ifdef DUTY_RAMP_WATCHDOG_EN
        // watchdog: silence after reaching 20 trips at accept+WDT, then ramps down
        drive(1, 20, 0); tick();
        drive(0, 0, 0);
        ticks(WDT - 1);
        check("t6_pre_trip", 32'(wdt_trip), 32'd0);
        tick();
        check("t6_trip", 32'(wdt_trip), 32'd1);
        check("t6_still20", 32'(duty_cycle), 32'd20);
        ticks(4 * RT + 2);
        check("t6_rampdown", 32'(duty_cycle), 32'd0);
        drive(1, 10, 0); tick();
        drive(0, 0, 0);
        check("t6_clear", 32'(wdt_trip), 32'd0);
        ticks(3 * RT);
`endif

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            cmd_valid  = ($urandom_range(0, 7) == 0);
            cmd_target = (r < 15) ? 7'(m_duty) : 7'($urandom_range(0, 127));
            estop      = ($urandom_range(0, 80) == 0);
            tick();
        end
        drive(0, 0, 0);
        ticks(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/duty_ramp.md
# duty_ramp

Slew-rate limiter directly upstream of the motor PWM generator. Accepts a target duty cycle (percent, 0–100) over a valid/ready handshake and steps the live duty value toward it by at most STEP percent every RAMP_TICKS clocks. Drives the PWM's `duty_cycle`/`en` load pair so motor current never sees a step change. An emergency stop input forces the duty to zero immediately.

## Interface
- `RAMP_TICKS`, 17'd100_000: clocks between successive duty steps; ≥ 1.
- `STEP`, 7'd5: max duty change per step; 1..100.
- `WDT_CYCLES`, 32'd50_000_000: command-silence timeout, used only with the watchdog macro.
- `clk` in 1: system clock.
- `clr` in 1: asynchronous, active-high reset.
- `cmd_target` in 7: requested duty, percent.
- `cmd_valid` in 1: `cmd_target` is valid.
- `cmd_ready` out 1: command can be accepted this cycle.
- `estop` in 1: synchronous emergency stop, level-sensitive.
- `duty_cycle` out 7: live duty, registered, to the PWM.
- `en` out 1: one-cycle load strobe to the PWM.
- `busy` out 1: ramp in progress.
- `wdt_trip` out 1: watchdog expired, sticky.

## Operation
- Reset values: `duty_cycle`=0, `en`=0, `busy`=0, `wdt_trip`=0, internal target=0, tick counter=0, state IDLE. `cmd_ready`=0 while `clr` is high, then 1 in the first cycle after release.
- States:
  - IDLE: `cmd_ready` = !`estop`. If valid&&ready, latch target = min(`cmd_target`, 100); values 101..127 clamp to 100. If the latched target equals `duty_cycle`, stay in IDLE. Otherwise go to RAMP and clear the tick counter.
  - RAMP: `busy`=1, `cmd_ready`=0. The tick counter counts 0..RAMP_TICKS-1.
    - At the wrap edge, `duty_cycle` moves toward target by min(STEP, |target−duty|). It never overshoots.
    - If the new duty equals target, return to IDLE on that same edge.
- Arithmetic: use 8-bit internal difference and sum so nothing wraps. `duty_cycle` is never > 100.
- `en`: high for exactly the one cycle after any edge that changes `duty_cycle`. Never high when the value is unchanged.
- `estop`: highest priority, evaluated every cycle.
  - Next edge: `duty_cycle`=0, target=0, state IDLE, tick counter cleared.
  - `en` pulses only if duty was non-zero.
  - Held high: `cmd_ready`=0, so a simultaneous `cmd_valid` is dropped.
- `clr` mid-ramp aborts to reset values asynchronously. No `en` pulse is issued.

## Timing
- Accept at edge N → `busy`=1 from cycle N+1.
- First step at edge N+RAMP_TICKS. `en`=1 during the cycle that follows it.
- Step k lands at edge N+k·RAMP_TICKS.
- Final step edge: `busy`→0 and `cmd_ready`→1 on that same edge.
- Full 0→100 ramp with STEP=5 takes 20·RAMP_TICKS clocks after accept.
- `estop` asserted in cycle M → `duty_cycle`=0 after edge M. Latency is one clock.

## Configuration
- `DUTY_RAMP_WATCHDOG_EN` defined:
  - A WDT_CYCLES counter restarts on every accepted command.
  - On expiry (IDLE or RAMP), the target is forced to 0 and the block ramps down at the normal rate, not immediately. `wdt_trip` is set.
  - `wdt_trip` clears on the next accepted command.
  - `estop` does not reset the watchdog.
- Not defined: no watchdog counter, `wdt_trip` tied to 0, port retained.

## Structure
- Shared `motor_pkg`:
  - `DUTY_W`=7, `DUTY_MAX`=7'd100.
  - typedef `duty_t` (logic [6:0]).
  - enum `ramp_state_e` {IDLE, RAMP}.
- One sub-module, `duty_ramp_tick`: parameterised free counter with sync clear, enable and a one-cycle `wrap` output at RAMP_TICKS-1. Instantiated once.
- The watchdog counter is inline and guarded by the macro.

## Test plan
1. Reset, then `cmd_target`=40, STEP=5, RAMP_TICKS=4 → `duty_cycle` 5,10,…,40 at edges N+4…N+32; 8 `en` pulses; `busy` falls with the last step.
2. From 40, `cmd_target`=37 → single step to 37 at N+4, one `en`, no overshoot.
3. `cmd_target`=120 from 0 → clamps, ends at 100. `cmd_target`=duty while IDLE → no `en`, `busy` stays 0.
4. `estop` pulsed mid-ramp at duty 25 with `cmd_valid` high → duty 0 next edge, one `en`, command dropped, `cmd_ready` 1 after `estop` falls.
5. `clr` asserted mid-ramp → all outputs 0 immediately. After release, `cmd_ready`=1 next cycle.
6. Macro on, WDT_CYCLES=50, duty 20, no commands → `wdt_trip`=1 at cycle 50, ramps to 0. A new command clears `wdt_trip`.
